// File: rtl/snake_control_if.sv
// Signal bundle between the snake game controller and its game-state/VGA neighbours.
// The master side drives game state, heading and pixel address; the slave (snake_control) returns colour and score.
interface snake_control_if;
  logic [1:0]  MASTER_STATE;
  logic [1:0]  DIRECTION;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [6:0]  TARGET_H;
  logic [5:0]  TARGET_V;
  logic [11:0] COLOUR_IN;
  logic        REACHED_TARGET;
  logic [3:0]  SCORE;

  modport master (
    output MASTER_STATE, DIRECTION, ADDRH, ADDRV, TARGET_H, TARGET_V,
    input  COLOUR_IN, REACHED_TARGET, SCORE
  );

  modport slave (
    input  MASTER_STATE, DIRECTION, ADDRH, ADDRV, TARGET_H, TARGET_V,
    output COLOUR_IN, REACHED_TARGET, SCORE
  );
endinterface

// File: rtl/snake_control.sv
// Snake body, heading and score on an 80x60 grid of 8x8-pixel cells, plus the
// registered per-pixel colour lookup feeding the VGA display stage.
module snake_control #(
  parameter int SNAKE_LENGTH = 20,
  parameter int MOVE_PERIOD  = 5000000
) (
  input  logic           CLK,
  input  logic           RESET,
  snake_control_if.slave bus
);

  localparam int TICK_W = $clog2(MOVE_PERIOD);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_WIN  = 2'b10,
    GS_ALT  = 2'b11
  } game_e;

  typedef struct packed {
    logic [6:0] col;
    logic [5:0] row;
  } cell_t;

  function automatic cell_t init_cell(input int idx);
    return '{col: 7'(40 - idx), row: 6'd30};
  endfunction

  cell_t             body [SNAKE_LENGTH];
  dir_e              heading;
  dir_e              pending;
  logic [TICK_W-1:0] tick;
  logic [3:0]        score;
  logic              reached;
  logic [11:0]       colour;

  logic  in_idle;
  logic  in_play;
  logic  move;
  logic  opposite;
  dir_e  request;
  cell_t new_head;
  cell_t pix;
  cell_t target;
  logic  unused_sub_cell_bits;

  assign pix     = {bus.ADDRH[9:3], bus.ADDRV[8:3]};
  assign target  = {bus.TARGET_H, bus.TARGET_V};
  assign request = dir_e'(bus.DIRECTION);
  assign unused_sub_cell_bits = ^{bus.ADDRH[2:0], bus.ADDRV[2:0]};

  // Opposite headings differ only in bit 1 (up/down = 00/10, right/left = 01/11).
  assign opposite = ((request ^ heading) == 2'b10);
  assign move     = in_play && (tick == TICK_W'(MOVE_PERIOD - 1));

  // NOTE: every signal driven from always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    in_idle = 1'b0;
    in_play = 1'b0;
    case (game_e'(bus.MASTER_STATE))
      GS_PLAY: in_play = 1'b1;
      GS_WIN:  ;
      default: in_idle = 1'b1;
    endcase
  end

  always_comb begin
    new_head = body[0];
    case (pending)
      DIR_UP:    new_head.row = (body[0].row == 6'd0)  ? 6'd59 : body[0].row - 6'd1;
      DIR_RIGHT: new_head.col = (body[0].col == 7'd79) ? 7'd0  : body[0].col + 7'd1;
      DIR_DOWN:  new_head.row = (body[0].row == 6'd59) ? 6'd0  : body[0].row + 6'd1;
      DIR_LEFT:  new_head.col = (body[0].col == 7'd0)  ? 7'd79 : body[0].col - 7'd1;
      default:   new_head = body[0];
    endcase
  end

  // NOTE: the body array is a handful of flops rather than a RAM, so it is reset like any other register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < SNAKE_LENGTH; i++) body[i] <= init_cell(i);
      heading <= DIR_RIGHT;
      pending <= DIR_RIGHT;
      tick    <= '0;
      score   <= 4'd0;
      reached <= 1'b0;
    end else if (in_idle) begin
      for (int i = 0; i < SNAKE_LENGTH; i++) body[i] <= init_cell(i);
      heading <= DIR_RIGHT;
      pending <= DIR_RIGHT;
      tick    <= '0;
      score   <= 4'd0;
      reached <= 1'b0;
    end else if (in_play) begin
      reached <= 1'b0;
      if (!opposite) pending <= request;
      if (move) begin
        // NOTE: non-blocking assignments make every segment read its neighbour's pre-edge value, so loop order does not matter.
        for (int i = SNAKE_LENGTH - 1; i > 0; i--) body[i] <= body[i-1];
        body[0] <= new_head;
        heading <= pending;
        tick    <= '0;
        if (new_head == target) begin
          reached <= 1'b1;
          if (score != 4'd15) score <= score + 4'd1;
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end else begin
      reached <= 1'b0;
    end
  end

  logic        on_head;
  logic        on_body;
  logic [11:0] colour_next;

  always_comb begin
    on_head = (body[0] == pix);
    on_body = 1'b0;
    for (int i = 1; i < SNAKE_LENGTH; i++) begin
      if (body[i] == pix) on_body = 1'b1;
    end
    if (on_head)            colour_next = 12'hF80;
    else if (on_body)       colour_next = 12'hFF0;
    else if (pix == target) colour_next = 12'hF00;
    else                    colour_next = 12'h444;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) colour <= 12'h000;
    else        colour <= colour_next;
  end

  assign bus.COLOUR_IN      = colour;
  assign bus.REACHED_TARGET = reached;
  assign bus.SCORE          = score;

endmodule
